// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing types, default oversample ratio and divisor helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  localparam int OVERSAMPLE_DEFAULT = 16;
  function automatic int default_div(input int freq, input int baud, input int os);
    return freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_tick_divider.sv
// uart_tick_divider: loadable down-counter; ports clk/rst, run (count enable), load/load_val (forced reload), period_m1 (auto reload on tick), tick (count==0 while running)
module uart_tick_divider #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] period_m1,
  output logic             tick
);
  logic [WIDTH-1:0] count;
  assign tick = run && count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= RST_VAL;
    else if (load) count <= load_val;
    else if (tick) count <= period_m1;
    else if (run) count <= count - 1'b1;
endmodule

// File: rtl/uart_baud_scheduler.sv
// uart_baud_scheduler: runtime-programmable baud tick generator; ports: clock/reset, enable_in, cfg req/div/ack/err handshake, rx_sample_tick_out, tx_bit_tick_out, div_out, running_out
module uart_baud_scheduler
  import uart_pkg::*;
#(
  parameter int SYSTM_OPERN_FREQ  = 11059200,
  parameter int DEFAULT_BAUD_RATE = 9600,
  parameter int OVERSAMPLE        = OVERSAMPLE_DEFAULT,
  parameter int DIV_WIDTH         = 16
) (
  input  logic                 systm_clock_in,
  input  logic                 systm_reset_in,
  input  logic                 enable_in,
  input  logic                 cfg_req_in,
  input  logic [DIV_WIDTH-1:0] cfg_div_in,
  output logic                 cfg_ack_out,
  output logic                 cfg_err_out,
  output logic                 rx_sample_tick_out,
  output logic                 tx_bit_tick_out,
  output logic [DIV_WIDTH-1:0] div_out,
  output logic                 running_out
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(default_div(SYSTM_OPERN_FREQ, DEFAULT_BAUD_RATE, OVERSAMPLE));
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  state_t state, nxt;
  logic [DIV_WIDTH-1:0] div_reg, load_val;
  logic [OSW-1:0] os_ctr;
  logic ack, err, loaded, rx_q, tx_q;
  logic sample, bit_now, accept, bad, apply, reject, load, running;
  assign running  = state != IDLE;
  assign bit_now  = sample && os_ctr == OS_LAST;
  // loaded blocks re-acceptance during the cycle between the divisor load and the ack
  assign accept   = cfg_req_in && !ack && !loaded;
  assign bad      = cfg_div_in == '0;
  assign load     = apply || nxt == IDLE;
  assign load_val = apply ? cfg_div_in - 1'b1 : div_reg - 1'b1;
  uart_tick_divider #(.WIDTH(DIV_WIDTH), .RST_VAL(DEFAULT_DIV - 1'b1)) u_div (
    .clk(systm_clock_in), .rst(systm_reset_in), .run(running), .load(load),
    .load_val(load_val), .period_m1(div_reg - 1'b1), .tick(sample)
  );
  always_comb begin
    nxt = state;
    apply = 1'b0;
    reject = 1'b0;
    case (state)
      IDLE: begin
        apply = accept && !bad;
        reject = accept && bad;
        nxt = enable_in ? RUN : IDLE;
      end
      RUN: begin
        reject = accept && bad;
        nxt = !enable_in ? IDLE : (accept && !bad) ? PEND : RUN;
      end
      PEND: begin
        apply = bit_now;
        nxt = !enable_in ? IDLE : bit_now ? RUN : PEND;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge systm_clock_in or posedge systm_reset_in)
    if (systm_reset_in) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge systm_clock_in or posedge systm_reset_in)
    if (systm_reset_in) begin
      div_reg <= DEFAULT_DIV;
      os_ctr <= '0;
      loaded <= 1'b0;
      ack <= 1'b0;
      err <= 1'b0;
      rx_q <= 1'b0;
      tx_q <= 1'b0;
    end else begin
      if (apply) div_reg <= cfg_div_in;
      os_ctr <= load ? '0 : !sample ? os_ctr : (os_ctr == OS_LAST) ? '0 : os_ctr + 1'b1;
      loaded <= apply;
      ack <= loaded || reject || (ack && cfg_req_in);
      err <= reject || (err && ack && cfg_req_in);
      rx_q <= sample;
      tx_q <= bit_now;
    end
  assign cfg_ack_out        = ack;
  assign cfg_err_out        = err;
  assign rx_sample_tick_out = rx_q;
  assign tx_bit_tick_out    = tx_q;
  assign div_out            = div_reg;
  assign running_out        = running;
endmodule
